grf_scoreboard: RTL and testbench
=================================

# grf_scoreboard

Register-availability scoreboard for the 32×32 general register file (GRF) in the five-stage MIPS pipeline. It tracks in-flight writes per architectural register between D-stage issue and W-stage writeback. It stalls issue on read-after-write hazards and on counter saturation, and counts total outstanding writes. It does not touch GRF data; it sequences GRF access by gating issue.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- CNT_W, 2, width of each per-register pending counter (maximum CNT_MAX = 2^CNT_W − 1 = 3).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  D-stage instruction requests issue.
- iss_rs, iss_rt  in  5  source register indices.
- iss_rs_use, iss_rt_use  in  1  the corresponding source is actually read.
- iss_rd  in  5  destination register index.
- iss_rd_we  in  1  the instruction writes iss_rd.
- iss_ready  out  1  combinational; issue is accepted when iss_valid && iss_ready.
- ret_valid  in  1  W-stage GRF write this cycle (same as GRF write-enable).
- ret_a3  in  5  W-stage write index.
- flush  in  1  pipeline flush; all in-flight writes are cancelled.
- busy  out  1  registered; 1 when any counter is nonzero.
- outstanding  out  7  registered; sum of all counters (0..93).
- err  out  1  registered, sticky; set on retire underflow.

## Operation
- State: cnt[r] for r = 1..31, each CNT_W bits; cnt[0] does not exist and always reads 0.
- Hazard: a source hazard exists when src_use is 1, src is not 0, and eff_cnt[src] is not 0. A saturation hazard exists when iss_rd_we is 1, iss_rd is not 0, and cnt[iss_rd] equals CNT_MAX.
- iss_ready = !flush && !rs hazard && !rt hazard && !saturation hazard. It is independent of iss_valid.
- Issue increment: iss_valid && iss_ready && iss_rd_we && iss_rd != 0 increments cnt[iss_rd].
- Write-after-write hazards are not stalled; the pipeline retires writes in order.
- Retire decrement: ret_valid && ret_a3 != 0 decrements cnt[ret_a3]. If cnt[ret_a3] is 0, the counter holds at 0 and err is set.
- Retire to register 0 is ignored.
- Same register incremented and decremented in one cycle: the counter is unchanged.
- Flush: all counters are cleared, and any issue or retire in the same cycle is ignored. err is not cleared by flush.
- outstanding and busy are recomputed from the next-state counters, so they are valid one cycle after the triggering edge.

## Timing
- Reset values: all cnt = 0, outstanding = 0, busy = 0, err = 0. iss_ready = 1 after reset (unless flush is asserted).
- rst asserted mid-operation takes priority over flush, issue and retire.
- An issue at edge N makes cnt[rd] visible, and hence a stall for dependents, from cycle N+1.
- A retire at edge N clears the hazard from cycle N+1, or in the same cycle when the bypass feature (see Configuration) is compiled in.
- No multicycle paths.
- iss_ready is combinational from iss_* inputs, ret_* inputs, flush and registered state. There is no path from iss_valid to iss_ready.

## Configuration
- GRF_SB_RETIRE_BYPASS_EN defined: eff_cnt[r] = cnt[r] − (ret_valid && ret_a3 == r). A register whose last pending write retires this cycle does not stall a same-cycle reader. This matches a GRF with write-through forwarding.
- GRF_SB_RETIRE_BYPASS_EN undefined: eff_cnt = cnt, and the reader stalls one extra cycle.
- The saturation check always uses the stored cnt, regardless of the macro.

## Structure
- Shared package grf_sb_pkg holds:
  - constants NREG, CNT_W, CNT_MAX, OUT_W = 7;
  - typedef reg_idx_t (5 bits) and typedef sb_cnt_t (CNT_W bits).
- Sub-module grf_sb_counter: one saturating up/down counter with inc, dec and clr inputs, and count and underflow outputs. It is instantiated 31 times.
- The top level holds:
  - hazard/ready logic;
  - outstanding adder tree;
  - sticky err.

## Test plan
- Reset, then issue rd=5 with rd_we: next cycle outstanding=1 and busy=1. An issue with rs=5 and rs_use=1 gives iss_ready=0. Retire a3=5: next cycle iss_ready=1 and outstanding=0.
- Issue rd=0 with rd_we: outstanding stays 0. rs=rt=0 with use=1 never stalls. Retire a3=0: err stays 0.
- Three accepted issues to rd=7 give cnt=3 and outstanding=3. A fourth issue to rd=7 sees iss_ready=0, while an issue to rd=8 is accepted.
- cnt[9]=1, then issue rd=9 and retire a3=9 in the same cycle: cnt[9] stays 1 and outstanding stays 1.
- Retire a3=3 with cnt[3]=0: err=1 next cycle and stays 1 through a flush. Only rst clears it.
- Flush with outstanding=4 plus a same-cycle issue to rd=2: next cycle outstanding=0, busy=0 and cnt[2]=0.
- With cnt[4]=1, retire a3=4 in the same cycle as an issue with rs=4: iss_ready=1 with GRF_SB_RETIRE_BYPASS_EN defined, 0 without it.

Source files
------------

// File: rtl/grf_sb_pkg.sv
// ----------------------------------------------------------------------------
// grf_sb_pkg
// Shared constants and types for the GRF register-availability scoreboard.
//   NREG    : number of architectural registers (register 0 is hard-wired zero)
//   CNT_W   : width of each per-register pending-write counter
//   CNT_MAX : largest value a pending counter can hold
//   OUT_W   : width of the total-outstanding count (0..(NREG-1)*CNT_MAX)
// ----------------------------------------------------------------------------
package grf_sb_pkg;

    localparam int NREG    = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int OUT_W   = 7;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/grf_sb_counter.sv
// ----------------------------------------------------------------------------
// grf_sb_counter
// Pending-write counter for one architectural register. Counts up on issue,
// down on retire, holds when both happen together, never wraps in either
// direction. Clear wins over inc/dec and suppresses underflow reporting.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous, active-high reset
//   i_inc         in   an accepted issue targets this register
//   i_dec         in   a W-stage write to this register retires
//   i_clr         in   flush: drop every pending write
//   o_count       out  registered pending count
//   o_count_nxt   out  value o_count will take at the next edge
//   o_underflow   out  retire seen while nothing was pending (combinational)
// ----------------------------------------------------------------------------
module grf_sb_counter
    import grf_sb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_nxt,
    output logic         o_underflow
);

    localparam logic [W-1:0] W_MAX = '1;

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;
    logic         w_underflow;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_count_nxt = r_count;
        w_underflow = 1'b0;
        if (i_clr) begin
            w_count_nxt = '0;
        end else begin
            // A retire with nothing pending is an error even if an issue to
            // the same register lands this cycle: that issue cannot be the
            // one retiring.
            w_underflow = i_dec && (r_count == '0);
            if (i_inc && !i_dec && (r_count != W_MAX)) begin
                w_count_nxt = r_count + 1'b1;
            end else if (i_dec && !i_inc && (r_count != '0)) begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking
        // assignments so every flop samples pre-edge values.
        if (rst) r_count <= '0;
        else     r_count <= w_count_nxt;
    end

    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_underflow = w_underflow;

endmodule

// File: rtl/grf_scoreboard.sv
// ----------------------------------------------------------------------------
// grf_scoreboard
// Register-availability scoreboard for the 32x32 GRF of the five-stage MIPS
// pipeline. Tracks in-flight writes per register between D-stage issue and
// W-stage writeback, stalls issue on RAW hazards and on counter saturation,
// and reports the total number of outstanding writes.
//
// Build option: define GRF_SB_RETIRE_BYPASS_EN when the GRF forwards its
// write port to same-cycle readers; a register whose last pending write
// retires this cycle then no longer stalls a reader in that cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_iss_valid              D-stage instruction requests issue
//   i_iss_rs/_rt, *_use      source indices and whether each is read
//   i_iss_rd, i_iss_rd_we    destination index and write enable
//   o_iss_ready              combinational issue grant (no path from valid)
//   i_ret_valid, i_ret_a3    W-stage GRF write enable and index
//   i_flush                  cancel every in-flight write
//   o_busy                   registered: any write pending
//   o_outstanding            registered: total pending writes
//   o_err                    registered, sticky: retire underflow seen
// ----------------------------------------------------------------------------
module grf_scoreboard
    import grf_sb_pkg::reg_idx_t;
    import grf_sb_pkg::OUT_W;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_iss_valid,
    input  reg_idx_t         i_iss_rs,
    input  reg_idx_t         i_iss_rt,
    input  logic             i_iss_rs_use,
    input  logic             i_iss_rt_use,
    input  reg_idx_t         i_iss_rd,
    input  logic             i_iss_rd_we,
    output logic             o_iss_ready,
    input  logic             i_ret_valid,
    input  reg_idx_t         i_ret_a3,
    input  logic             i_flush,
    output logic             o_busy,
    output logic [OUT_W-1:0] o_outstanding,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Index 0 is a constant-zero slot so register indices can be used
    // directly; only 1..NREG-1 have real counters.
    logic [CNT_W-1:0] w_cnt     [NREG];
    logic [CNT_W-1:0] w_cnt_nxt [1:NREG-1];
    logic [NREG-1:1]  w_inc;
    logic [NREG-1:1]  w_dec;
    logic [NREG-1:1]  w_underflow;

    logic             w_issue_fire;
    logic             w_rs_haz;
    logic             w_rt_haz;
    logic             w_sat_haz;
    logic [OUT_W-1:0] w_sum;

    logic             r_busy;
    logic [OUT_W-1:0] r_outstanding;
    logic             r_err;

    assign w_cnt[0] = '0;

    assign w_issue_fire = i_iss_valid && o_iss_ready && i_iss_rd_we && (i_iss_rd != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign w_inc[r] = w_issue_fire && (i_iss_rd == reg_idx_t'(r));
        assign w_dec[r] = i_ret_valid && (i_ret_a3 == reg_idx_t'(r));

        grf_sb_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc[r]),
            .i_dec       (w_dec[r]),
            .i_clr       (i_flush),
            .o_count     (w_cnt[r]),
            .o_count_nxt (w_cnt_nxt[r]),
            .o_underflow (w_underflow[r])
        );
    end

    // A source is free when nothing is pending, or (with the bypass) when the
    // only pending write is being written back right now.
`ifdef GRF_SB_RETIRE_BYPASS_EN
    assign w_rs_haz = i_iss_rs_use && (i_iss_rs != '0) && (w_cnt[i_iss_rs] != '0)
                   && !((w_cnt[i_iss_rs] == CNT_W'(1)) && i_ret_valid && (i_ret_a3 == i_iss_rs));
    assign w_rt_haz = i_iss_rt_use && (i_iss_rt != '0) && (w_cnt[i_iss_rt] != '0)
                   && !((w_cnt[i_iss_rt] == CNT_W'(1)) && i_ret_valid && (i_ret_a3 == i_iss_rt));
`else
    assign w_rs_haz = i_iss_rs_use && (i_iss_rs != '0) && (w_cnt[i_iss_rs] != '0);
    assign w_rt_haz = i_iss_rt_use && (i_iss_rt != '0) && (w_cnt[i_iss_rt] != '0);
`endif

    // Saturation looks at the stored count only: a same-cycle retire does not
    // make room for a new issue.
    assign w_sat_haz = i_iss_rd_we && (i_iss_rd != '0) && (w_cnt[i_iss_rd] == CNT_MAX);

    assign o_iss_ready = !i_flush && !w_rs_haz && !w_rt_haz && !w_sat_haz;

    // Total of the next-state counters, so the registered total lines up with
    // the counters it describes.
    always_comb begin
        w_sum = '0;
        for (int r = 1; r < NREG; r++) begin
            w_sum = w_sum + OUT_W'(w_cnt_nxt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_sum;
            r_busy        <= (w_sum != '0);
            // Sticky: only reset clears it, flush does not.
            r_err         <= r_err || (|w_underflow);
        end
    end

    assign o_outstanding = r_outstanding;
    assign o_busy        = r_busy;
    assign o_err         = r_err;

endmodule

// File: tb/tb_grf_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_grf_scoreboard
// Self-checking bench for grf_scoreboard. A behavioural model predicts
// iss_ready before each edge and pushes the expected registered outputs to a
// scoreboard queue; they are popped and compared after the edge. Scenario
// tasks add directed checks against fixed expected values.
// ----------------------------------------------------------------------------
module tb_grf_scoreboard;
    import grf_sb_pkg::*;

    typedef struct {
        logic [OUT_W-1:0] outstanding;
        logic             busy;
        logic             err;
    } exp_t;

`ifdef GRF_SB_RETIRE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             iss_valid, iss_rs_use, iss_rt_use, iss_rd_we;
    reg_idx_t         iss_rs, iss_rt, iss_rd, ret_a3;
    logic             ret_valid, flush;
    logic             iss_ready, busy, err;
    logic [OUT_W-1:0] outstanding;

    int checks = 0;
    int errors = 0;

    sb_cnt_t m_cnt [NREG];
    logic    m_err;
    exp_t    sb_q [$];

    always #5 clk = ~clk;

    grf_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .i_iss_valid   (iss_valid),
        .i_iss_rs      (iss_rs),
        .i_iss_rt      (iss_rt),
        .i_iss_rs_use  (iss_rs_use),
        .i_iss_rt_use  (iss_rt_use),
        .i_iss_rd      (iss_rd),
        .i_iss_rd_we   (iss_rd_we),
        .o_iss_ready   (iss_ready),
        .i_ret_valid   (ret_valid),
        .i_ret_a3      (ret_a3),
        .i_flush       (flush),
        .o_busy        (busy),
        .o_outstanding (outstanding),
        .o_err         (err)
    );

    function automatic logic model_src_haz(reg_idx_t src, logic use_src);
        if (!use_src || src == 0 || m_cnt[src] == 0) return 1'b0;
        if (BYP && m_cnt[src] == sb_cnt_t'(1) && ret_valid && ret_a3 == src) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_ready();
        logic sat;
        sat = iss_rd_we && iss_rd != 0 && m_cnt[iss_rd] == sb_cnt_t'(CNT_MAX);
        return !flush && !model_src_haz(iss_rs, iss_rs_use)
                      && !model_src_haz(iss_rt, iss_rt_use) && !sat;
    endfunction

    task automatic set_in(input logic v, input int rs, input logic rs_u, input int rt,
                          input logic rt_u, input int rd, input logic we,
                          input logic rv, input int a3, input logic fl);
        iss_valid  = v;
        iss_rs     = reg_idx_t'(rs);
        iss_rs_use = rs_u;
        iss_rt     = reg_idx_t'(rt);
        iss_rt_use = rt_u;
        iss_rd     = reg_idx_t'(rd);
        iss_rd_we  = we;
        ret_valid  = rv;
        ret_a3     = reg_idx_t'(a3);
        flush      = fl;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: predict, push expectations, take the edge, pop and compare.
    task automatic tick(input string tag);
        logic exp_ready, inc, dec;
        int   sum;
        exp_t e;
        #1;
        exp_ready = model_ready();
        if (!rst) begin
            checks++;
            if (iss_ready !== exp_ready) begin
                errors++;
                $display("FAIL %s iss_ready: got %b expected %b", tag, iss_ready, exp_ready);
            end
        end
        if (rst) begin
            foreach (m_cnt[r]) m_cnt[r] = '0;
            m_err = 1'b0;
        end else if (flush) begin
            foreach (m_cnt[r]) m_cnt[r] = '0;
        end else begin
            inc = iss_valid && exp_ready && iss_rd_we && iss_rd != 0;
            dec = ret_valid && ret_a3 != 0;
            if (dec && m_cnt[ret_a3] == 0) m_err = 1'b1;
            if (!(inc && dec && iss_rd == ret_a3)) begin
                if (inc && m_cnt[iss_rd] != sb_cnt_t'(CNT_MAX)) m_cnt[iss_rd] = m_cnt[iss_rd] + 1'b1;
                if (dec && m_cnt[ret_a3] != 0) m_cnt[ret_a3] = m_cnt[ret_a3] - 1'b1;
            end
        end
        sum = 0;
        foreach (m_cnt[r]) sum += int'(m_cnt[r]);
        sb_q.push_back('{outstanding: OUT_W'(sum), busy: (sum != 0), err: m_err});

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (outstanding !== e.outstanding || busy !== e.busy || err !== e.err) begin
            errors++;
            $display("FAIL %s outputs: got out=%0d busy=%b err=%b expected out=%0d busy=%b err=%b",
                     tag, outstanding, busy, err, e.outstanding, e.busy, e.err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 5, 1, 0, 0, 6, 1, 1, 3, 1);   // everything active: reset must win
        tick("reset");
        tick("reset_hold");
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (iss_ready !== 1'b1 || outstanding !== 7'd0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b out=%0d busy=%b err=%b expected 1 0 0 0",
                     iss_ready, outstanding, busy, err);
        end
    endtask

    task automatic test_raw_hazard();
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        tick("raw_issue");
        checks++;
        if (outstanding !== 7'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL raw_issue_out: got out=%0d busy=%b expected 1 1", outstanding, busy);
        end
        set_in(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall: got %b expected 0", iss_ready);
        end
        tick("raw_stall");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        tick("raw_retire");
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (iss_ready !== 1'b1 || outstanding !== 7'd0) begin
            errors++;
            $display("FAIL raw_release: got rdy=%b out=%0d expected 1 0", iss_ready, outstanding);
        end
        tick("raw_release");
    endtask

    task automatic test_reg_zero();
        set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_src_ready: got %b expected 1", iss_ready);
        end
        tick("zero_issue");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick("zero_retire");
        checks++;
        if (outstanding !== 7'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_effect: got out=%0d err=%b expected 0 0", outstanding, err);
        end
    endtask

    task automatic test_saturation();
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        repeat (3) tick("sat_fill");
        checks++;
        if (outstanding !== 7'd3) begin
            errors++;
            $display("FAIL sat_fill_out: got %0d expected 3", outstanding);
        end
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_stall: got %b expected 0", iss_ready);
        end
        tick("sat_stall");
        set_in(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_other_reg: got %b expected 1", iss_ready);
        end
        tick("sat_other_reg");
        checks++;
        if (outstanding !== 7'd4) begin
            errors++;
            $display("FAIL sat_total: got %0d expected 4", outstanding);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick("sat_flush");
    endtask

    task automatic test_inc_dec_same();
        set_in(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        tick("incdec_prime");
        set_in(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
        tick("incdec_same");
        checks++;
        if (outstanding !== 7'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL incdec_hold: got out=%0d err=%b expected 1 0", outstanding, err);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        tick("incdec_drain");
    endtask

    task automatic test_underflow_flush();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        tick("uflow_retire");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL uflow_err: got %b expected 1", err);
        end
        for (int r = 10; r < 14; r++) begin
            set_in(1, 0, 0, 0, 0, r, 1, 0, 0, 0);
            tick("uflow_fill");
        end
        set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 1);
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 0", iss_ready);
        end
        tick("flush_issue");
        checks++;
        if (outstanding !== 7'd0 || busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got out=%0d busy=%b err=%b expected 0 0 1",
                     outstanding, busy, err);
        end
        set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        tick("flush_reg2");
        checks++;
        if (outstanding !== 7'd1) begin
            errors++;
            $display("FAIL flush_reg2_count: got %0d expected 1", outstanding);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick("flush_clean");
    endtask

    task automatic test_bypass();
        rst = 1'b1;
        idle();
        tick("bypass_reset");
        rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL rst_clears_err: got %b expected 0", err);
        end
        set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        tick("bypass_prime");
        set_in(1, 4, 1, 0, 0, 0, 0, 1, 4, 0);
        #1;
        checks++;
        if (iss_ready !== BYP) begin
            errors++;
            $display("FAIL bypass_ready: got %b expected %b", iss_ready, BYP);
        end
        tick("bypass_same_cycle");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 4), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 4), $urandom_range(0, 1) == 1, $urandom_range(0, 5),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 5), $urandom_range(0, 24) == 0);
            tick("random");
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        foreach (m_cnt[r]) m_cnt[r] = '0;
        m_err = 1'b0;
        test_reset();
        test_raw_hazard();
        test_reg_zero();
        test_saturation();
        test_inc_dec_same();
        test_underflow_flush();
        test_bypass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
